// File: rtl/frame_capture_sched.sv
`default_nettype none
// ============================================================================
// frame_capture_sched: round-robin share of one frame-capture sink between
// NUM_SRC video sources; frame-aligned grant, settle-frame skip, stall timeout.
// Revision: 1.0
// ============================================================================
module frame_capture_sched #(
    parameter int NUM_SRC     = 3,
    parameter int DATA_WIDTH  = 24,
    parameter int SKIP_FRAMES = 1,
    parameter int TIMEOUT_CYC = 2**22
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_SRC-1:0]            src_vsync,
    input  logic [NUM_SRC-1:0]            src_hsync,
    input  logic [NUM_SRC-1:0]            src_de,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] src_data,
    input  logic [NUM_SRC-1:0]            req,
    output logic                          cap_vsync,
    output logic                          cap_hsync,
    output logic                          cap_de,
    output logic [DATA_WIDTH-1:0]         cap_data,
    output logic [$clog2(NUM_SRC)-1:0]    grant_idx,
    output logic                          busy,
    output logic                          done,
    output logic                          timeout,
    output logic [31:0]                   pix_cnt
);

    localparam int GW = $clog2(NUM_SRC);

    localparam logic [2:0] C_IDLE    = 3'd0;
    localparam logic [2:0] C_ARB     = 3'd1;
    localparam logic [2:0] C_SYNC    = 3'd2;
    localparam logic [2:0] C_CAPTURE = 3'd3;
    localparam logic [2:0] C_DONE    = 3'd4;

    logic [2:0]         r_state;
    logic [2:0]         w_state_nxt;
    logic [NUM_SRC-1:0] r_vsync_d1;
    logic [NUM_SRC-1:0] w_fe;
    logic [GW-1:0]      r_last_grant;
    logic [GW-1:0]      w_pick;
    logic [GW-1:0]      w_cand;
    logic               w_pick_vld;
    logic [31:0]        r_skip_cnt;
    logic [31:0]        r_tmo_cnt;
    logic [31:0]        r_pix_acc;
    logic               w_fe_g;
    logic               w_de_g;
    logic               w_tc;
    logic               w_waiting;

    assign w_fe      = r_vsync_d1 & ~src_vsync;
    assign w_fe_g    = w_fe[grant_idx];
    assign w_de_g    = src_de[grant_idx];
    assign w_tc      = (r_tmo_cnt == 32'(TIMEOUT_CYC - 1));
    assign w_waiting = (r_state == C_SYNC) || (r_state == C_CAPTURE);

    // Round-robin: scan upward from the source after the last one served.
    always_comb begin
        w_pick     = '0;
        w_cand     = '0;
        w_pick_vld = 1'b0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            w_cand = GW'((int'(r_last_grant) + k) % NUM_SRC);
            if (!w_pick_vld && req[w_cand]) begin
                w_pick     = w_cand;
                w_pick_vld = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= C_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            C_IDLE:    if (|req) w_state_nxt = C_ARB;
            C_ARB:     w_state_nxt = w_pick_vld ? C_SYNC : C_IDLE;
            C_SYNC: begin
                if (w_fe_g) begin
                    if (r_skip_cnt == '0) w_state_nxt = C_CAPTURE;
                end else if (w_tc) begin
                    w_state_nxt = C_IDLE;
                end
            end
            C_CAPTURE: begin
                if (w_fe_g)    w_state_nxt = C_DONE;
                else if (w_tc) w_state_nxt = C_IDLE;
            end
            C_DONE:    w_state_nxt = C_IDLE;
            default:   w_state_nxt = C_IDLE;
        endcase
    end

    // A boundary on the terminal-count cycle takes priority over the timeout.
    always_comb begin
        done    = 1'b0;
        timeout = 1'b0;
        if (r_state == C_DONE) done = 1'b1;
        if (w_waiting && w_tc && !w_fe_g) timeout = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vsync_d1   <= '0;
            r_last_grant <= GW'(NUM_SRC - 1);
            grant_idx    <= '0;
            busy         <= 1'b0;
            r_skip_cnt   <= '0;
            r_tmo_cnt    <= '0;
            r_pix_acc    <= '0;
            pix_cnt      <= '0;
        end else begin
            r_vsync_d1 <= src_vsync;
            case (r_state)
                C_ARB: begin
                    if (w_pick_vld) begin
                        grant_idx  <= w_pick;
                        busy       <= 1'b1;
                        r_skip_cnt <= 32'(SKIP_FRAMES);
                        r_tmo_cnt  <= '0;
                    end
                end
                C_SYNC, C_CAPTURE: begin
                    if (r_state == C_CAPTURE) r_pix_acc <= r_pix_acc + 32'(w_de_g);
                    if (w_fe_g) begin
                        r_tmo_cnt <= '0;
                        if (r_state == C_SYNC) begin
                            if (r_skip_cnt == '0) r_pix_acc  <= '0;
                            else                  r_skip_cnt <= r_skip_cnt - 32'd1;
                        end
                    end else if (w_tc) begin
                        busy         <= 1'b0;
                        r_last_grant <= grant_idx;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 32'd1;
                    end
                end
                C_DONE: begin
                    pix_cnt      <= r_pix_acc;
                    r_last_grant <= grant_idx;
                    busy         <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // The closing boundary cycle is forwarded too, so the sink sees vsync fall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_vsync <= 1'b0;
            cap_hsync <= 1'b0;
            cap_de    <= 1'b0;
            cap_data  <= '0;
        end else if (r_state == C_CAPTURE) begin
            cap_vsync <= src_vsync[grant_idx];
            cap_hsync <= src_hsync[grant_idx];
            cap_de    <= w_de_g;
            cap_data  <= src_data[grant_idx*DATA_WIDTH +: DATA_WIDTH];
        end else begin
            cap_vsync <= 1'b0;
            cap_hsync <= 1'b0;
            cap_de    <= 1'b0;
            cap_data  <= '0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_frame_capture_sched.sv
`default_nettype none
// ============================================================================
// tb_frame_capture_sched: directed scenarios against a frame-level model.
// Revision: 1.0
// ============================================================================
module tb_frame_capture_sched;

    localparam int NS   = 3;
    localparam int DW   = 24;
    localparam int SKIP = 1;
    localparam int TO   = 1000;
    localparam int HT   = 12;
    localparam int VT   = 8;
    localparam int FT   = HT * VT;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [NS-1:0]    src_vsync, src_hsync, src_de, req;
    logic [NS*DW-1:0] src_data;
    logic             cap_vsync, cap_hsync, cap_de, busy, done, timeout;
    logic [DW-1:0]    cap_data;
    logic [1:0]       grant_idx;
    logic [31:0]      pix_cnt;

    int checks = 0;
    int errors = 0;

    logic          rst_v;
    logic [NS-1:0] req_v;
    int            pos [NS];
    int            fcnt[NS];
    bit            stuck[NS];
    bit            hold[NS];

    // Frame-level model: grant record plus count of boundaries seen since grant.
    bit            m_arb, m_active, m_deliver;
    int            m_src, m_last, m_seen, m_idle;
    logic [31:0]   m_acc;
    logic [NS-1:0] m_pv;
    logic          e_cv, e_ch, e_cd, e_busy;
    logic [DW-1:0] e_data;
    logic [1:0]    e_gidx;
    logic [31:0]   e_pix;

    int   cyc = 0, c0 = 0, to_cyc = 0, to_cnt = 0, done_cnt = 0, de_seen = 0, dc = 0, t0 = 0;
    logic busy_prev = 1'b0;
    int   grants[$];

    frame_capture_sched #(
        .NUM_SRC    (NS),
        .DATA_WIDTH (DW),
        .SKIP_FRAMES(SKIP),
        .TIMEOUT_CYC(TO)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .src_vsync (src_vsync),
        .src_hsync (src_hsync),
        .src_de    (src_de),
        .src_data  (src_data),
        .req       (req),
        .cap_vsync (cap_vsync),
        .cap_hsync (cap_hsync),
        .cap_de    (cap_de),
        .cap_data  (cap_data),
        .grant_idx (grant_idx),
        .busy      (busy),
        .done      (done),
        .timeout   (timeout),
        .pix_cnt   (pix_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int grant_at(input int i);
        return (i < grants.size()) ? grants[i] : -1;
    endfunction

    // 12x8 raster: vsync lines 0-1, active lines 3-6 with 8 pixels each.
    task automatic gen_drive();
        for (int s = 0; s < NS; s++) begin
            int ln;
            int px;
            ln = pos[s] / HT;
            px = pos[s] % HT;
            src_vsync[s] = (ln < 2) && !stuck[s];
            src_hsync[s] = (px >= 10);
            src_de[s]    = (ln >= 3) && (ln <= 6) && (px < 8);
            src_data[s*DW +: DW] = {8'(s), 8'(fcnt[s]), 8'(pos[s])};
        end
    endtask

    task automatic gen_advance();
        for (int s = 0; s < NS; s++) begin
            if (!(hold[s] && pos[s] == 23)) begin
                pos[s]++;
                if (pos[s] == FT) begin
                    pos[s] = 0;
                    fcnt[s]++;
                end
            end
        end
        gen_drive();
    endtask

    task automatic model_reset();
        m_arb = 0; m_active = 0; m_deliver = 0;
        m_src = 0; m_last = NS - 1; m_seen = 0; m_idle = 0;
        m_acc = '0; m_pv = '0;
        e_cv = 0; e_ch = 0; e_cd = 0; e_data = '0; e_busy = 0; e_gidx = '0; e_pix = '0;
    endtask

    task automatic compare_and_step();
        logic [NS-1:0] fe;
        bit            cap_on;
        if (!rst_v) model_reset();
        fe = m_pv & ~src_vsync;
        chk("cap_vsync", cap_vsync, e_cv);
        chk("cap_hsync", cap_hsync, e_ch);
        chk("cap_de", cap_de, e_cd);
        chk("cap_data", cap_data, e_data);
        chk("busy", busy, e_busy);
        chk("grant_idx", grant_idx, e_gidx);
        chk("pix_cnt", pix_cnt, e_pix);
        chk("done", done, m_deliver);
        chk("timeout", timeout, m_active && (m_idle == TO - 1) && !fe[m_src]);

        if (busy === 1'b1 && busy_prev !== 1'b1) begin
            c0 = cyc;
            grants.push_back(int'(grant_idx));
        end
        busy_prev = busy;
        if (done === 1'b1) done_cnt++;
        if (timeout === 1'b1) begin
            to_cnt++;
            to_cyc = cyc;
        end
        if (cap_de === 1'b1) de_seen++;

        if (rst_v) begin
            cap_on = m_active && (m_seen >= SKIP + 1);
            e_cv   = cap_on ? src_vsync[m_src] : 1'b0;
            e_ch   = cap_on ? src_hsync[m_src] : 1'b0;
            e_cd   = cap_on ? src_de[m_src]    : 1'b0;
            e_data = cap_on ? src_data[m_src*DW +: DW] : '0;
            if (m_deliver) begin
                e_pix = m_acc; m_last = m_src; e_busy = 0; m_deliver = 0;
            end else if (m_arb) begin
                m_arb = 0;
                for (int k = 1; k <= NS; k++) begin
                    if (!m_active && req[(m_last + k) % NS]) begin
                        m_src    = (m_last + k) % NS;
                        m_active = 1;
                    end
                end
                if (m_active) begin
                    e_gidx = 2'(m_src); e_busy = 1; m_seen = 0; m_idle = 0;
                end
            end else if (m_active) begin
                if (cap_on) m_acc = m_acc + 32'(src_de[m_src]);
                if (fe[m_src]) begin
                    m_seen++;
                    m_idle = 0;
                    if (m_seen == SKIP + 1) m_acc = '0;
                    if (m_seen == SKIP + 2) begin
                        m_active = 0; m_deliver = 1;
                    end
                end else if (m_idle == TO - 1) begin
                    m_active = 0; e_busy = 0; m_last = m_src;
                end else begin
                    m_idle++;
                end
            end else if (|req) begin
                m_arb = 1;
            end
            m_pv = src_vsync;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        rst_n = rst_v;
        req   = req_v;
        gen_advance();
        @(negedge clk);
        cyc++;
        compare_and_step();
    endtask

    task automatic wait_busy(input string nm, input int lim);
        int n;
        n = 0;
        while (busy !== 1'b1 && n < lim) begin
            tick();
            n++;
        end
        chk(nm, {63'b0, busy === 1'b1}, 64'd1);
    endtask

    task automatic wait_done(input string nm, input int lim);
        int n;
        int d0;
        n  = 0;
        d0 = done_cnt;
        while (done_cnt == d0 && n < lim) begin
            tick();
            n++;
        end
        chk(nm, {63'b0, done_cnt != d0}, 64'd1);
        tick();
    endtask

    initial begin
        rst_n = 1'b0; rst_v = 1'b0; req = '0; req_v = '0;
        for (int s = 0; s < NS; s++) begin
            pos[s] = s * 30; fcnt[s] = 0; stuck[s] = 0; hold[s] = 0;
        end
        gen_drive();
        model_reset();
        repeat (3) tick();
        chk("rst_busy", busy, 0);
        chk("rst_pix_cnt", pix_cnt, 0);
        chk("rst_grant", grant_idx, 0);
        chk("rst_cap_vsync", cap_vsync, 0);
        rst_v = 1'b1;

        // Single requester: second frame of src0 delivered, 8x4 active pixels.
        grants.delete(); de_seen = 0;
        req_v = 3'b001;
        wait_busy("t1_busy", 10);
        req_v = '0;
        wait_done("t1_done", 400);
        chk("t1_grant", grant_at(0), 0);
        chk("t1_pix_cnt", pix_cnt, 32);
        chk("t1_sink_de", de_seen, 32);
        chk("t1_done_cnt", done_cnt, 1);

        // All requesting after reset: strict rotation 0,1,2,0.
        rst_v = 1'b0; tick(); tick(); rst_v = 1'b1; tick();
        grants.delete();
        req_v = 3'b111;
        for (int n = 0; n < 2000 && grants.size() < 4; n++) tick();
        req_v = '0;
        chk("t2_grant_count", grants.size(), 4);
        wait_done("t2_done", 400);
        chk("t2_grant0", grant_at(0), 0);
        chk("t2_grant1", grant_at(1), 1);
        chk("t2_grant2", grant_at(2), 2);
        chk("t2_grant3", grant_at(3), 0);

        // Request only long enough to be arbitrated; capture still completes.
        grants.delete();
        req_v = 3'b010; tick(); tick(); req_v = '0;
        wait_done("t3_done", 400);
        chk("t3_grant", grant_at(0), 1);
        chk("t3_pix_cnt", pix_cnt, 32);

        // src2 never produces a boundary: timeout on the 1000th waiting cycle.
        stuck[2] = 1; repeat (3) tick();
        grants.delete(); to_cnt = 0; de_seen = 0;
        req_v = 3'b100;
        wait_busy("t4_busy", 10);
        req_v = '0;
        t0 = c0;
        for (int n = 0; n < 1100 && to_cnt == 0; n++) tick();
        chk("t4_timeout_cnt", to_cnt, 1);
        chk("t4_timeout_delay", to_cyc - t0, 999);
        chk("t4_grant", grant_at(0), 2);
        chk("t4_sink_de", de_seen, 0);
        chk("t4_pix_held", pix_cnt, 32);
        tick();
        chk("t4_busy_clear", busy, 0);
        req_v = 3'b001;
        wait_busy("t4_next_busy", 10);
        req_v = '0;
        chk("t4_next_grant", grant_at(1), 0);
        wait_done("t4_next_done", 400);
        stuck[2] = 0;

        // Boundary lands exactly on the terminal-count cycle: no timeout.
        hold[0] = 1;
        for (int n = 0; n < 200 && pos[0] != 23; n++) tick();
        chk("t5_parked", pos[0], 23);
        to_cnt = 0; grants.delete();
        req_v = 3'b001;
        wait_busy("t5_busy", 10);
        req_v = '0;
        t0 = c0;
        while (cyc < t0 + 998) tick();
        hold[0] = 0;
        tick();
        chk("t5_no_timeout", to_cnt, 0);
        chk("t5_still_busy", busy, 1);
        wait_done("t5_done", 400);
        chk("t5_pix_cnt", pix_cnt, 32);
        chk("t5_no_timeout_end", to_cnt, 0);

        // Reset in the middle of a capture.
        grants.delete();
        req_v = 3'b010;
        wait_busy("t6_busy", 10);
        req_v = '0;
        for (int n = 0; n < 400 && cap_de !== 1'b1; n++) tick();
        chk("t6_capturing", cap_de, 1);
        dc = done_cnt;
        rst_v = 1'b0;
        tick();
        chk("t6_rst_cap_de", cap_de, 0);
        chk("t6_rst_cap_data", cap_data, 0);
        chk("t6_rst_busy", busy, 0);
        tick();
        rst_v = 1'b1;
        req_v = 3'b011;
        wait_busy("t6_after_busy", 10);
        req_v = '0;
        chk("t6_after_grant", grant_at(1), 0);
        chk("t6_no_stale_done", done_cnt, dc);
        wait_done("t6_after_done", 400);
        chk("t6_pix_cnt", pix_cnt, 32);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
